imem_fetch_sequencer: RTL and testbench

- Controller for the single-port, byte-wide instruction block RAM (8-bit data, 1-cycle synchronous read latency).
- Shares the RAM between two requesters:
  - the instruction-fetch stage, which requests 32-bit words;
  - the boot program loader, which writes single bytes.
- For each fetch, issues four sequential byte reads through one RAM port and assembles a little-endian 32-bit instruction. This replaces four parallel RAM copies.

---
 rtl/imem_fetch_sequencer.sv | 164 ++++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_sequencer
// Brief    : Shares a byte-wide 1-cycle-latency instruction RAM between the
//            fetch stage (32-bit little-endian words via four byte reads) and
//            the boot loader (byte writes, strict priority while idle).
//            Optional macro IMEM_MISALIGN_CHECK_EN: unaligned fetches return
//            NOP_INSTR with fetch_error instead of touching the RAM.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_sequencer #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  input  logic              fetch_flush,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic              fetch_error,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ack,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dina,
  input  logic [7:0]        mem_douta
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [23:0]       buf_q, buf_d;
  logic [31:0]       instr_q, instr_d;

  // Address bits above the RAM size are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^fetch_addr[31:ADDR_W];

`ifdef IMEM_MISALIGN_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    buf_d       = buf_q;
    instr_d     = instr_q;
`ifdef IMEM_MISALIGN_CHECK_EN
    err_d       = err_q;
`endif
    fetch_ready = 1'b0;
    load_ack    = 1'b0;
    mem_ena     = 1'b0;
    mem_wea     = 1'b0;
    mem_addr    = '0;
    mem_dina    = '0;
    instr_valid = 1'b0;
    fetch_error = 1'b0;

    case (state_q)
      S_IDLE: begin
        fetch_ready = ~load_we;
        if (load_we) begin
          mem_ena  = 1'b1;
          mem_wea  = 1'b1;
          mem_addr = load_addr;
          mem_dina = load_data;
          load_ack = 1'b1;
        end else if (fetch_req && !fetch_flush) begin
          base_d  = fetch_addr[ADDR_W-1:0];
          cnt_d   = 2'd0;
          buf_d   = '0;
          state_d = S_ISSUE;
`ifdef IMEM_MISALIGN_CHECK_EN
          err_d   = 1'b0;
          if (fetch_addr[1:0] != 2'b00) begin
            instr_d = NOP_INSTR;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end

      S_ISSUE: begin
        mem_ena  = 1'b1;
        mem_addr = base_q + ADDR_W'(cnt_q);
        // Read data lags the address by one cycle: capture the previous byte.
        case (cnt_q)
          2'd1:    buf_d[7:0]   = mem_douta;
          2'd2:    buf_d[15:8]  = mem_douta;
          2'd3:    buf_d[23:16] = mem_douta;
          default: ;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_DRAIN;
        end
        if (fetch_flush) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (fetch_flush) begin
          state_d = S_IDLE;
        end else begin
          instr_d = {mem_douta, buf_q};
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        instr_valid = ~fetch_flush;
`ifdef IMEM_MISALIGN_CHECK_EN
        fetch_error = err_q & ~fetch_flush;
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      base_q  <= '0;
      buf_q   <= '0;
      instr_q <= '0;
`ifdef IMEM_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
`ifdef IMEM_MISALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign instruction = instr_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_sequencer
// Brief    : Self-checking bench for imem_fetch_sequencer with a behavioural
//            byte RAM and a reference byte-array model of loader writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_sequencer;

  localparam int          ADDR_W = 12;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_flush;
  logic              instr_valid;
  logic [31:0]       instruction;
  logic              fetch_error;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_ack;
  logic              mem_ena;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dina;
  logic [7:0]        mem_douta;

  always #5 clk = ~clk;

  imem_fetch_sequencer #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_flush(fetch_flush), .instr_valid(instr_valid), .instruction(instruction),
    .fetch_error(fetch_error), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_ack(load_ack), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addr(mem_addr), .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  // Single-port byte RAM with one-cycle read latency.
  logic [7:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_ena) begin
      if (mem_wea) ram[mem_addr] <= mem_dina;
      else         mem_douta     <= ram[mem_addr];
    end
  end

  logic [7:0] ref_mem [0:(1<<ADDR_W)-1];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: word is four loader-written bytes, little-endian, wrapping.
  function automatic logic [32:0] model(input logic [31:0] addr);
    logic [ADDR_W-1:0] a;
    a = addr[ADDR_W-1:0];
    if (MIS && a[1:0] != 2'b00) return {1'b1, NOP};
    return {1'b0, ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]};
  endfunction

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    #1;
    check("wr_ack", load_ack, 1);
    check("wr_ctrl", {mem_ena, mem_wea}, 2'b11);
    check("wr_addr", mem_addr, a);
    check("wr_data", mem_dina, d);
    tick;
    load_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Called in the cycle after the accept edge; follows the fetch to the pulse.
  task automatic wait_resp(input logic [31:0] addr, input logic [31:0] exp, input bit err);
    int c;
    logic [ADDR_W-1:0] ea;
    c = 1;
    while (!instr_valid && c <= 20) begin
      if (err) begin
        check("mis_no_ram", mem_ena, 0);
      end else if (c <= 4) begin
        ea = addr[ADDR_W-1:0] + 12'(c - 1);
        check("rd_ctrl", {mem_ena, mem_wea}, 2'b10);
        check("rd_addr", mem_addr, ea);
      end else begin
        check("drain_ena", mem_ena, 0);
      end
      check("busy_ack", load_ack, 0);
      tick;
      c++;
    end
    check("latency", c, err ? 1 : 6);
    check("instr", instruction, exp);
    check("fetch_error", fetch_error, err);
    tick;
    check("valid_pulse", instr_valid, 0);
    check("instr_hold", instruction, exp);
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    logic [32:0] m;
    int w;
    w = 0;
    while (!fetch_ready && w < 20) begin tick; w++; end
    check("ready_wait", fetch_ready, 1);
    m = model(addr);
    fetch_req = 1'b1; fetch_addr = addr;
    tick;
    fetch_req = 1'b0;
    wait_resp(addr, m[31:0], m[32]);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] raw;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cnt_v;
    logic [32:0] m;
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_error, 0);
    check("rst_instr", instruction, 0);
    check("rst_ack", load_ack, 0);
    check("rst_mem", {mem_ena, mem_wea, mem_dina}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_ready", fetch_ready, 1);

    // Preload through the loader.
    do_write(12'h010, 8'h13); do_write(12'h011, 8'h00);
    do_write(12'h012, 8'h00); do_write(12'h013, 8'h00);
    do_write(12'h014, 8'h5A); do_write(12'h015, 8'hC3);
    do_write(12'hFFC, 8'h11); do_write(12'hFFD, 8'h22);
    do_write(12'hFFE, 8'hAA); do_write(12'hFFF, 8'hBB);
    do_write(12'h000, 8'hCC); do_write(12'h001, 8'hDD);
    do_write(12'h100, 8'h78); do_write(12'h101, 8'h56);
    do_write(12'h102, 8'h34); do_write(12'h103, 8'h12);

    tbl[0] = '{32'h0000_0010, 32'h0000_0013};
    tbl[1] = '{32'h0000_0FFE, 32'hDDCC_BBAA};
    tbl[2] = '{32'h8000_0100, 32'h1234_5678};
    tbl[3] = '{32'h0000_0011, 32'h5A00_0000};
    tbl[4] = '{32'h0000_0012, 32'hC35A_0000};
    tbl[5] = '{32'hFFFF_FFFC, 32'hBBAA_2211};
    for (int i = 0; i < 6; i++) begin
      bit e;
      e = MIS && (tbl[i].addr[1:0] != 2'b00);
      fetch_req = 1'b1; fetch_addr = tbl[i].addr;
      tick;
      fetch_req = 1'b0;
      wait_resp(tbl[i].addr, e ? NOP : tbl[i].raw, e);
    end

    // Loader and fetch in the same idle cycle: loader wins.
    fetch_req = 1'b1; fetch_addr = 32'h100;
    load_we = 1'b1; load_addr = 12'h020; load_data = 8'h99;
    #1;
    check("lw_ready", fetch_ready, 0);
    check("lw_ack", load_ack, 1);
    tick;
    load_we = 1'b0; ref_mem[12'h020] = 8'h99;
    #1;
    check("lw_not_acc", mem_ena, 0);
    check("lw_ready2", fetch_ready, 1);
    tick;
    fetch_req = 1'b0;
    wait_resp(32'h100, 32'h1234_5678, 1'b0);
    check("lw_ram", ram[12'h020], 8'h99);

    // Loader request while busy: stalls until the fetch completes.
    fetch_req = 1'b1; fetch_addr = 32'h10;
    tick;
    fetch_req = 1'b0;
    load_we = 1'b1; load_addr = 12'h013; load_data = 8'h77;
    wait_resp(32'h10, 32'h0000_0013, 1'b0);
    check("stall_ack", load_ack, 1);
    check("stall_addr", mem_addr, 12'h013);
    tick;
    load_we = 1'b0; ref_mem[12'h013] = 8'h77;
    do_fetch(32'h10);
    do_write(12'h013, 8'h00);

    // Flush, then reset, in the second ISSUE cycle.
    for (int pass = 0; pass < 2; pass++) begin
      fetch_req = 1'b1; fetch_addr = 32'h100;
      tick;
      fetch_req = 1'b0;
      tick;
      if (pass == 0) fetch_flush = 1'b1; else rst = 1'b1;
      tick;
      fetch_flush = 1'b0; rst = 1'b0;
      check("abort_ready", fetch_ready, 1);
      check("abort_ena", mem_ena, 0);
      if (pass == 1) begin
        check("rst_mid_instr", instruction, 0);
        check("rst_mid_out", {instr_valid, fetch_error, load_ack, mem_wea, mem_dina}, 0);
        check("rst_mid_addr", mem_addr, 0);
      end
      cnt_v = 0;
      for (int k = 0; k < 8; k++) begin
        if (instr_valid) cnt_v++;
        tick;
      end
      check("abort_no_valid", cnt_v, 0);
      do_fetch(32'h10);
    end

    // Flush during RESP suppresses the pulse.
    fetch_req = 1'b1; fetch_addr = 32'h100;
    tick;
    fetch_req = 1'b0;
    repeat (5) tick;
    fetch_flush = 1'b1;
    #1;
    check("resp_flush_valid", instr_valid, 0);
    check("resp_flush_err", fetch_error, 0);
    tick;
    fetch_flush = 1'b0;
    check("resp_flush_after", instr_valid, 0);

    // Flush in IDLE beats a same-cycle request.
    fetch_req = 1'b1; fetch_flush = 1'b1; fetch_addr = 32'h10;
    tick;
    fetch_req = 1'b0; fetch_flush = 1'b0;
    check("idle_flush_ena", mem_ena, 0);
    tick;
    check("idle_flush_valid", instr_valid, 0);

    // Randomized traffic in a window against the reference model.
    for (int i = 0; i < 64; i++) do_write(12'h200 + 12'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write(12'h200 + 12'($urandom_range(0, 63)), 8'($urandom));
      end else begin
        logic [31:0] ra;
        ra = {$urandom_range(0, 15) << 28} | (32'h200 + 32'($urandom_range(0, 60)));
        ra[27:12] = 16'($urandom);
        do_fetch(ra);
      end
    end

    m = model(32'h10);
    check("model_sanity", instruction == m[31:0] ? 0 : 1, instruction == m[31:0] ? 0 : 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
